// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN address generator: geometry helpers and the
// address bundle carried by the output stage of cnn_addr_gen.
package cnn_pkg;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnn_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Input feature-map height needed to cover R output rows.
  function automatic int unsigned cnn_ih(input int unsigned r, input int unsigned k,
                                         input int unsigned s);
    return (r - 1) * s + k;
  endfunction

  // Input feature-map width needed to cover C output columns.
  function automatic int unsigned cnn_iw(input int unsigned c, input int unsigned k,
                                         input int unsigned s);
    return (c - 1) * s + k;
  endfunction

  function automatic int unsigned cnn_in_aw(input int unsigned n, input int unsigned r,
                                            input int unsigned c, input int unsigned k,
                                            input int unsigned s);
    return cnn_w(n * cnn_ih(r, k, s) * cnn_iw(c, k, s));
  endfunction

  function automatic int unsigned cnn_wt_aw(input int unsigned m, input int unsigned n,
                                            input int unsigned k);
    return cnn_w(m * n * k * k);
  endfunction

  function automatic int unsigned cnn_out_aw(input int unsigned m, input int unsigned r,
                                             input int unsigned c);
    return cnn_w(m * r * c);
  endfunction

  // Default layer geometry; the bundle fields are sized from it.
  localparam int unsigned CNN_N = 4;
  localparam int unsigned CNN_M = 4;
  localparam int unsigned CNN_K = 2;
  localparam int unsigned CNN_R = 16;
  localparam int unsigned CNN_C = 16;
  localparam int unsigned CNN_S = 1;

  localparam int unsigned CNN_IN_AW  = cnn_in_aw(CNN_N, CNN_R, CNN_C, CNN_K, CNN_S);
  localparam int unsigned CNN_WT_AW  = cnn_wt_aw(CNN_M, CNN_N, CNN_K);
  localparam int unsigned CNN_OUT_AW = cnn_out_aw(CNN_M, CNN_R, CNN_C);

  typedef struct packed {
    logic [CNN_IN_AW-1:0]  in_addr;
    logic [CNN_WT_AW-1:0]  wt_addr;
    logic [CNN_OUT_AW-1:0] out_addr;
    logic                  acc_clear;
    logic                  acc_last;
    logic                  done;
  } cnn_addr_bundle_t;

endpackage

// File: rtl/cnn_pipe_stage.sv
// One valid/ready register slice: holds a single payload, loads when empty or
// when the successor takes the current payload in the same cycle.
module cnn_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign ready_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Slice register: payload only updates on an actual transfer in.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/cnn_addr_gen.sv
// CNN address generator: turns loop-index tuples into input, weight and output
// buffer addresses through a two-stage elastic pipeline.
// Optional: CNN_ADDR_BOUNDS_CHK_EN adds a sticky index-range error flag.
module cnn_addr_gen
  import cnn_pkg::*;
#(
  parameter int unsigned N_p  = 4,
  parameter int unsigned M_p  = 4,
  parameter int unsigned K_p  = 2,
  parameter int unsigned R_p  = 16,
  parameter int unsigned C_p  = 16,
  parameter int unsigned Tn_p = 2,
  parameter int unsigned Tm_p = 2,
  parameter int unsigned S_p  = 1
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic                                        valid_i,
  output logic                                        ready_o,
  input  logic [cnn_w(K_p)-1:0]                       j_i,
  input  logic [cnn_w(K_p)-1:0]                       i_i,
  input  logic [cnn_w(N_p)-1:0]                       ti_i,
  input  logic [cnn_w(M_p)-1:0]                       to_i,
  input  logic [cnn_w(C_p)-1:0]                       col_i,
  input  logic [cnn_w(R_p)-1:0]                       row_i,
  input  logic                                        done_i,
  output logic                                        valid_o,
  input  logic                                        ready_i,
  output logic [cnn_in_aw(N_p,R_p,C_p,K_p,S_p)-1:0]   in_addr_o,
  output logic [cnn_wt_aw(M_p,N_p,K_p)-1:0]           wt_addr_o,
  output logic [cnn_out_aw(M_p,R_p,C_p)-1:0]          out_addr_o,
  output logic                                        acc_clear_o,
  output logic                                        acc_last_o,
  output logic                                        done_o,
  output logic                                        err_o
);

  localparam int unsigned IH     = cnn_ih(R_p, K_p, S_p);
  localparam int unsigned IW     = cnn_iw(C_p, K_p, S_p);
  localparam int unsigned IN_AW  = cnn_in_aw(N_p, R_p, C_p, K_p, S_p);
  localparam int unsigned WT_AW  = cnn_wt_aw(M_p, N_p, K_p);
  localparam int unsigned OUT_AW = cnn_out_aw(M_p, R_p, C_p);
  localparam int unsigned KW     = cnn_w(K_p);
  localparam int unsigned NW     = cnn_w(N_p);

  localparam logic [IN_AW-1:0]  S_IN    = IN_AW'(S_p);
  localparam logic [IN_AW-1:0]  IH_IN   = IN_AW'(IH);
  localparam logic [IN_AW-1:0]  IW_IN   = IN_AW'(IW);
  localparam logic [WT_AW-1:0]  N_WT    = WT_AW'(N_p);
  localparam logic [WT_AW-1:0]  K_WT    = WT_AW'(K_p);
  localparam logic [OUT_AW-1:0] R_OUT   = OUT_AW'(R_p);
  localparam logic [OUT_AW-1:0] C_OUT   = OUT_AW'(C_p);
  localparam logic [NW-1:0]     TI_LAST = NW'(N_p - Tn_p);
  localparam logic [KW-1:0]     K_LAST  = KW'(K_p - 1);

  if (((N_p % Tn_p) != 0) || ((M_p % Tm_p) != 0)) begin : g_bad_tile
    $error("cnn_addr_gen: channel counts must be multiples of their tile sizes");
  end

  // Partial sums held between the stages. Everything is kept at the width of
  // the address it feeds, so wraparound matches the final modular result.
  typedef struct packed {
    logic [IN_AW-1:0]  ih;   // row*S + i
    logic [IN_AW-1:0]  iw;   // col*S + j
    logic [IN_AW-1:0]  ti;
    logic [WT_AW-1:0]  tn;   // to*N + ti
    logic [KW-1:0]     i;
    logic [KW-1:0]     j;
    logic [OUT_AW-1:0] tr;   // to*R + row
    logic [OUT_AW-1:0] col;
    logic              acc_clear;
    logic              acc_last;
    logic              done;
  } s1_t;

  s1_t              s1_d, s1_q;
  cnn_addr_bundle_t s2_d, s2_q;
  logic             s1_valid, s2_ready, s2_valid;

  // Stage 1 inputs: first level of the address arithmetic plus the flags.
  always_comb begin
    s1_d           = '0;
    s1_d.ih        = IN_AW'(row_i) * S_IN + IN_AW'(i_i);
    s1_d.iw        = IN_AW'(col_i) * S_IN + IN_AW'(j_i);
    s1_d.ti        = IN_AW'(ti_i);
    s1_d.tn        = WT_AW'(to_i) * N_WT + WT_AW'(ti_i);
    s1_d.i         = i_i;
    s1_d.j         = j_i;
    s1_d.tr        = OUT_AW'(to_i) * R_OUT + OUT_AW'(row_i);
    s1_d.col       = OUT_AW'(col_i);
    s1_d.acc_clear = (ti_i == '0) & (i_i == '0) & (j_i == '0);
    s1_d.acc_last  = (ti_i == TI_LAST) & (i_i == K_LAST) & (j_i == K_LAST);
    s1_d.done      = done_i;
  end

  // Stage 2 inputs: finish the three addresses from the stage-1 partials.
  always_comb begin
    s2_d           = '0;
    s2_d.in_addr   = (s1_q.ti * IH_IN + s1_q.ih) * IW_IN + s1_q.iw;
    s2_d.wt_addr   = (s1_q.tn * K_WT + WT_AW'(s1_q.i)) * K_WT + WT_AW'(s1_q.j);
    s2_d.out_addr  = s1_q.tr * C_OUT + s1_q.col;
    s2_d.acc_clear = s1_q.acc_clear;
    s2_d.acc_last  = s1_q.acc_last;
    s2_d.done      = s1_q.done;
  end

  cnn_pipe_stage #(.W($bits(s1_t))) u_stage1 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (s1_d),
    .valid_o   (s1_valid),
    .ready_i   (s2_ready),
    .data_o    (s1_q)
  );

  cnn_pipe_stage #(.W($bits(cnn_addr_bundle_t))) u_stage2 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .valid_i   (s1_valid),
    .ready_o   (s2_ready),
    .data_i    (s2_d),
    .valid_o   (s2_valid),
    .ready_i   (ready_i),
    .data_o    (s2_q)
  );

  assign valid_o     = s2_valid;
  assign in_addr_o   = s2_q.in_addr;
  assign wt_addr_o   = s2_q.wt_addr;
  assign out_addr_o  = s2_q.out_addr;
  assign acc_clear_o = s2_q.acc_clear;
  assign acc_last_o  = s2_q.acc_last;
  // Stale payload stays in stage 2 after a pop; done must not outlive valid.
  assign done_o      = s2_valid & s2_q.done;

`ifdef CNN_ADDR_BOUNDS_CHK_EN
  logic idx_bad;
  logic err_q;

  // Range and tile-alignment violations of the incoming tuple.
  always_comb begin
    idx_bad = (32'(j_i) >= K_p) | (32'(i_i) >= K_p) |
              (32'(col_i) >= C_p) | (32'(row_i) >= R_p) |
              (32'(ti_i) > (N_p - Tn_p)) | ((32'(ti_i) % Tn_p) != 32'd0) |
              (32'(to_i) > (M_p - Tm_p)) | ((32'(to_i) % Tm_p) != 32'd0);
  end

  // Sticky error, set by any accepted out-of-range tuple.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else if (valid_i && ready_o && idx_bad) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
